// File: rtl/demux_1to2_buf_if.sv
// demux_1to2_buf_if
// Bundles the producer stream, both consumer streams and the debug counters
// of the 1-to-2 buffered demultiplexer.
//   slave  : the demux itself (takes the input stream, drives both outputs)
//   master : the surrounding producer/consumer logic (or a testbench)
// Signals:
//   in_data/in_sel/in_valid/in_ready    producer stream, in_sel picks channel
//   outK_data/outK_valid/outK_ready     consumer stream for channel K
//   cnt0/cnt1                           words delivered per channel (wrapping)
interface demux_1to2_buf_if #(
    parameter int DWIDTH = 32,
    parameter int CWIDTH = 16
);
    logic [DWIDTH-1:0] in_data;
    logic              in_sel;
    logic              in_valid;
    logic              in_ready;

    logic [DWIDTH-1:0] out0_data;
    logic              out0_valid;
    logic              out0_ready;

    logic [DWIDTH-1:0] out1_data;
    logic              out1_valid;
    logic              out1_ready;

    logic [CWIDTH-1:0] cnt0;
    logic [CWIDTH-1:0] cnt1;

    modport slave (
        input  in_data, in_sel, in_valid, out0_ready, out1_ready,
        output in_ready, out0_data, out0_valid, out1_data, out1_valid, cnt0, cnt1
    );

    modport master (
        output in_data, in_sel, in_valid, out0_ready, out1_ready,
        input  in_ready, out0_data, out0_valid, out1_data, out1_valid, cnt0, cnt1
    );
endinterface

// File: rtl/demux_1to2_buf.sv
// demux_1to2_buf
// Steers a single valid/ready word stream to one of two consumers, chosen per
// word by in_sel. Each channel owns a 2-entry FIFO so a stalled consumer on
// one side absorbs two words before the producer is held off.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; clears occupancy, pointers,
//          counters and data registers
//   bus    demux_1to2_buf_if.slave (input stream, two output streams, counters)
module demux_1to2_buf #(
    parameter int DWIDTH = 32,
    parameter int CWIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    demux_1to2_buf_if.slave       bus
);

    logic [DWIDTH-1:0] mem_reg    [2][2];
    logic [1:0]        occ_reg    [2];
    logic              wr_ptr_reg [2];
    logic              rd_ptr_reg [2];
    logic [CWIDTH-1:0] cnt_reg    [2];

    logic [1:0] push;
    logic [1:0] pop;
    logic [1:0] cons_ready;
    logic       accept;

    // Readiness depends only on the selected channel's registered occupancy,
    // so there is no combinational path from the consumers back to the producer.
    assign bus.in_ready = bus.in_sel ? (occ_reg[1] != 2'd2) : (occ_reg[0] != 2'd2);
    assign accept       = bus.in_valid && bus.in_ready;

    assign push[0] = accept && !bus.in_sel;
    assign push[1] = accept &&  bus.in_sel;

    assign cons_ready[0] = bus.out0_ready;
    assign cons_ready[1] = bus.out1_ready;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            assign pop[gi] = (occ_reg[gi] != 2'd0) && cons_ready[gi];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mem_reg[gi][0]  <= '0;
                    mem_reg[gi][1]  <= '0;
                    occ_reg[gi]     <= 2'd0;
                    wr_ptr_reg[gi]  <= 1'b0;
                    rd_ptr_reg[gi]  <= 1'b0;
                    cnt_reg[gi]     <= '0;
                end else begin
                    if (push[gi]) begin
                        mem_reg[gi][wr_ptr_reg[gi]] <= bus.in_data;
                        wr_ptr_reg[gi]              <= ~wr_ptr_reg[gi];
                    end
                    if (pop[gi]) begin
                        rd_ptr_reg[gi] <= ~rd_ptr_reg[gi];
                        cnt_reg[gi]    <= cnt_reg[gi] + 1'b1;
                    end
                    // Push+pop together leaves occupancy unchanged (only at occ==1).
                    case ({push[gi], pop[gi]})
                        2'b10:   occ_reg[gi] <= occ_reg[gi] + 2'd1;
                        2'b01:   occ_reg[gi] <= occ_reg[gi] - 2'd1;
                        default: occ_reg[gi] <= occ_reg[gi];
                    endcase
                end
            end
        end
    endgenerate

    // Head word comes straight from a register, so it stays stable while invalid.
    assign bus.out0_data  = mem_reg[0][rd_ptr_reg[0]];
    assign bus.out1_data  = mem_reg[1][rd_ptr_reg[1]];
    assign bus.out0_valid = (occ_reg[0] != 2'd0);
    assign bus.out1_valid = (occ_reg[1] != 2'd0);
    assign bus.cnt0       = cnt_reg[0];
    assign bus.cnt1       = cnt_reg[1];

endmodule

// File: tb/tb_demux_1to2_buf.sv
// tb_demux_1to2_buf
// Directed bench for demux_1to2_buf (CWIDTH = 4 so the counter wrap is cheap).
// Inputs change just after the falling edge; outputs are checked 1 ns later,
// i.e. they reflect the state left by the previous rising edge.
module tb_demux_1to2_buf;

    localparam int DW = 32;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    demux_1to2_buf_if #(.DWIDTH(DW), .CWIDTH(CW)) bus ();

    demux_1to2_buf #(.DWIDTH(DW), .CWIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic        sel;
        logic        valid;
        logic        r0;
        logic        r1;
        logic        e_rdy;
        logic        e_v0;
        logic [31:0] e_d0;
        logic        e_v1;
        logic [31:0] e_d1;
        logic [3:0]  e_c0;
        logic [3:0]  e_c1;
    } vec_t;

    vec_t vecs [15];

    function automatic vec_t mk(input logic [31:0] d, input logic s, v, a, b,
                                input logic rdy, v0, input logic [31:0] d0,
                                input logic v1, input logic [31:0] d1,
                                input logic [3:0] c0, c1);
        vec_t t;
        t.data = d; t.sel = s; t.valid = v; t.r0 = a; t.r1 = b;
        t.e_rdy = rdy; t.e_v0 = v0; t.e_d0 = d0; t.e_v1 = v1; t.e_d1 = d1;
        t.e_c0 = c0; t.e_c1 = c1;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic drive(input logic [31:0] d, input logic s, v, a, b);
        @(negedge clk);
        bus.in_data    = d;
        bus.in_sel     = s;
        bus.in_valid   = v;
        bus.out0_ready = a;
        bus.out1_ready = b;
        #1;
    endtask

    initial begin
        // data, sel, valid, r0, r1 | rdy, v0, d0, v1, d1, cnt0, cnt1
        // Alternating routing, both consumers ready.
        vecs[0]  = mk(32'hA0, 0, 1, 1, 1,  1, 0, 32'h00, 0, 32'h00, 4'd0, 4'd0);
        vecs[1]  = mk(32'hB1, 1, 1, 1, 1,  1, 1, 32'hA0, 0, 32'h00, 4'd0, 4'd0);
        vecs[2]  = mk(32'hA2, 0, 1, 1, 1,  1, 0, 32'h00, 1, 32'hB1, 4'd1, 4'd0);
        vecs[3]  = mk(32'hB3, 1, 1, 1, 1,  1, 1, 32'hA2, 0, 32'h00, 4'd1, 4'd1);
        vecs[4]  = mk(32'h00, 0, 0, 1, 1,  1, 0, 32'h00, 1, 32'hB3, 4'd2, 4'd1);
        vecs[5]  = mk(32'h00, 0, 0, 1, 1,  1, 0, 32'h00, 0, 32'h00, 4'd2, 4'd2);
        // Backpressure on channel 0: two accepted, third blocked.
        vecs[6]  = mk(32'h11, 0, 1, 0, 1,  1, 0, 32'h00, 0, 32'h00, 4'd2, 4'd2);
        vecs[7]  = mk(32'h22, 0, 1, 0, 1,  1, 1, 32'h11, 0, 32'h00, 4'd2, 4'd2);
        vecs[8]  = mk(32'h33, 0, 1, 0, 1,  0, 1, 32'h11, 0, 32'h00, 4'd2, 4'd2);
        // Channel 0 full: channel 1 still reachable, channel 0 still blocked.
        vecs[9]  = mk(32'h44, 1, 1, 0, 1,  1, 1, 32'h11, 0, 32'h00, 4'd2, 4'd2);
        vecs[10] = mk(32'h33, 0, 1, 0, 1,  0, 1, 32'h11, 1, 32'h44, 4'd2, 4'd2);
        vecs[11] = mk(32'h33, 0, 1, 1, 1,  0, 1, 32'h11, 0, 32'h00, 4'd2, 4'd3);
        vecs[12] = mk(32'h33, 0, 1, 1, 1,  1, 1, 32'h22, 0, 32'h00, 4'd3, 4'd3);
        vecs[13] = mk(32'h00, 0, 0, 1, 1,  1, 1, 32'h33, 0, 32'h00, 4'd4, 4'd3);
        vecs[14] = mk(32'h00, 0, 0, 1, 1,  1, 0, 32'h00, 0, 32'h00, 4'd5, 4'd3);

        bus.in_data = '0; bus.in_sel = 1'b0; bus.in_valid = 1'b0;
        bus.out0_ready = 1'b0; bus.out1_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset v0", 32'(bus.out0_valid), 32'd0);
        chk("reset v1", 32'(bus.out1_valid), 32'd0);
        chk("reset d0", bus.out0_data, 32'd0);
        chk("reset cnt0", 32'(bus.cnt0), 32'd0);
        chk("reset cnt1", 32'(bus.cnt1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].data, vecs[i].sel, vecs[i].valid, vecs[i].r0, vecs[i].r1);
            chk($sformatf("vec%0d in_ready", i), 32'(bus.in_ready), 32'(vecs[i].e_rdy));
            chk($sformatf("vec%0d v0", i), 32'(bus.out0_valid), 32'(vecs[i].e_v0));
            if (vecs[i].e_v0)
                chk($sformatf("vec%0d d0", i), bus.out0_data, vecs[i].e_d0);
            chk($sformatf("vec%0d v1", i), 32'(bus.out1_valid), 32'(vecs[i].e_v1));
            if (vecs[i].e_v1)
                chk($sformatf("vec%0d d1", i), bus.out1_data, vecs[i].e_d1);
            chk($sformatf("vec%0d cnt0", i), 32'(bus.cnt0), 32'(vecs[i].e_c0));
            chk($sformatf("vec%0d cnt1", i), 32'(bus.cnt1), 32'(vecs[i].e_c1));
        end

        // Channel 1 held at occupancy 1 with push and pop every cycle.
        drive(32'h100, 1, 1, 1, 1);
        chk("pp prime v1", 32'(bus.out1_valid), 32'd0);
        for (int k = 1; k <= 10; k++) begin
            drive(32'h100 + k, 1, 1, 1, 1);
            chk($sformatf("pp%0d in_ready", k), 32'(bus.in_ready), 32'd1);
            chk($sformatf("pp%0d v1", k), 32'(bus.out1_valid), 32'd1);
            chk($sformatf("pp%0d d1", k), bus.out1_data, 32'h100 + k - 1);
        end
        drive(32'h0, 0, 0, 1, 1);
        chk("pp cnt1 after 10", 32'(bus.cnt1), 32'd13);
        chk("pp last d1", bus.out1_data, 32'h10A);
        drive(32'h0, 0, 0, 1, 1);
        chk("pp drained v1", 32'(bus.out1_valid), 32'd0);
        chk("pp cnt1 final", 32'(bus.cnt1), 32'd14);

        // Fill channel 0, then reset mid-cycle with no clock edge.
        drive(32'h55, 0, 1, 0, 1);
        drive(32'h66, 0, 1, 0, 1);
        drive(32'h0, 0, 0, 0, 1);
        chk("full in_ready", 32'(bus.in_ready), 32'd0);
        chk("full d0", bus.out0_data, 32'h55);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst v0", 32'(bus.out0_valid), 32'd0);
        chk("async rst cnt0", 32'(bus.cnt0), 32'd0);
        chk("async rst cnt1", 32'(bus.cnt1), 32'd0);
        chk("async rst in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // 17 deliveries on channel 0 wrap the 4-bit counter to 1.
        for (int k = 0; k < 17; k++) begin
            drive(32'h200 + k, 0, 1, 1, 1);
            if (k > 0)
                chk($sformatf("wrap%0d d0", k), bus.out0_data, 32'h200 + k - 1);
        end
        drive(32'h0, 0, 0, 1, 1);
        chk("wrap last d0", bus.out0_data, 32'h210);
        chk("wrap cnt0 at 16", 32'(bus.cnt0), 32'd0);
        drive(32'h0, 0, 0, 1, 1);
        chk("wrap cnt0 at 17", 32'(bus.cnt0), 32'd1);
        chk("wrap drained v0", 32'(bus.out0_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_1to2_buf.md
# demux_1to2_buf

Registered 1-to-2 data demultiplexer with valid/ready handshaking and a 2-entry FIFO per output channel. It is the steering counterpart of the 2-to-1 select mux. A single producer stream (for example, ALU or load results) is routed by a per-word select bit to one of two independent consumers, such as the register-file write-back path and the memory store path. Per-channel transfer counters are exposed for debug and verification.

## Interface
- DWIDTH, 32, data word width in bits
- CWIDTH, 16, width of each per-channel transfer counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_data  in  DWIDTH  input word
- in_sel  in  1  destination (0 → channel 0, 1 → channel 1); sampled with in_data
- in_valid  in  1  producer has a word
- in_ready  out  1  word is accepted this cycle when in_valid && in_ready
- out0_data  out  DWIDTH  channel 0 head word
- out0_valid  out  1  channel 0 FIFO non-empty
- out0_ready  in  1  channel 0 consumer accepts head
- out1_data  out  DWIDTH  channel 1 head word
- out1_valid  out  1  channel 1 FIFO non-empty
- out1_ready  in  1  channel 1 consumer accepts head
- cnt0  out  CWIDTH  channel 0 words delivered, modulo 2^CWIDTH
- cnt1  out  CWIDTH  channel 1 words delivered, modulo 2^CWIDTH

## Operation
- Each channel has a 2-entry FIFO: two data registers, a 1-bit write pointer, a 1-bit read pointer and a 2-bit occupancy count (0..2).
- in_ready = (in_sel == 0) ? (occ0 != 2) : (occ1 != 2).
  - It is combinational from in_sel and registered occupancy only. It has no path from out*_ready.
- Push: when in_valid && in_ready, in_data is written at the selected channel's write pointer, and that pointer toggles. The unselected channel is untouched.
- Pop on channel k: when outk_valid && outk_ready, the read pointer toggles and cntk increments, wrapping from 2^CWIDTH−1 to 0.
- outk_valid = (occk != 0). outk_data = entry at read pointer. outk_data is don't-care when outk_valid is low but must stay stable (no glitching to X).
- Occupancy update per channel: push only → +1; pop only → −1; push and pop in the same cycle → unchanged. A simultaneous push and pop is only possible at occ = 1, because push is blocked at occ = 2.
- Ordering: words reach each channel in acceptance order. There is no ordering guarantee between channels.
- Full on the selected channel blocks input (in_ready = 0) even if the other channel is empty. No reordering, no bypass.
- No word is dropped or duplicated. A producer must hold in_data, in_sel and in_valid until the transfer completes.

## Timing
- Reset (rst_n low, asynchronous): occ0 = occ1 = 0, all pointers 0, cnt0 = cnt1 = 0, out0_valid = out1_valid = 0, data registers 0.
  - in_ready therefore reads 1 during reset; a transfer is not taken until after rst_n deasserts.
- Reset deasserts synchronously to clk at the bench. The first push is accepted on the first rising edge with rst_n high.
- Reset asserted mid-operation discards all buffered words immediately. Outputs take reset values without waiting for a clock edge.
- Latency: a word accepted at edge N appears with outk_valid = 1 immediately after edge N, if the FIFO was empty. Input-to-output latency is 1 cycle.
- Throughput: one word per cycle per channel sustained when the consumer holds ready high. A channel with a stalled consumer accepts exactly 2 words, then blocks.
- cntk updates at the same edge as the pop.

## Test plan
- Reset/idle: assert rst_n = 0 mid-stream with occ0 = 2 → out0_valid = 0, cnt0 = 0 with no clock edge. Release; in_ready = 1.
- Alternating routing: push 0xA0, 0xB1, 0xA2, 0xB3 with sel = 0, 1, 0, 1 and both readys high → channel 0 delivers A0, A2; channel 1 delivers B1, B3; each with 1-cycle latency; cnt0 = cnt1 = 2.
- Backpressure/full: out0_ready = 0, push 0x11, 0x22, 0x33 to channel 0 → first two accepted; in_ready = 0 on the third. Raise out0_ready → 0x11, 0x22, 0x33 delivered in order.
- Head-of-line block: channel 0 full, present sel = 1 → in_ready = 1 and the word goes to channel 1. Present sel = 0 → in_ready = 0 until a channel 0 pop.
- Simultaneous push/pop at occ = 1 on channel 1 for 10 cycles → occ1 stays 1, 10 words delivered in order, cnt1 = 10.
- Counter wrap with CWIDTH = 4: deliver 17 words on channel 0 → cnt0 = 1.
